// File: rtl/output_buf_pkg.sv
// output_buf_pkg: shared FSM state type and mode tags for the output block buffer.
package output_buf_pkg;
  typedef enum logic [1:0] {IDLE, SER, PAR} state_t;
  localparam logic MODE_SRAM = 1'b0;
  localparam logic MODE_I2C  = 1'b1;
endpackage

// File: rtl/output_block_buffer_if.sv
// output_block_buffer_if: SRAM byte-stream and I2C block handshakes leaving the buffer.
interface output_block_buffer_if #(parameter int BLOCK_W = 64, parameter int BYTE_W = 8);
  logic [BYTE_W-1:0]  sram_data;
  logic               sram_valid;
  logic               sram_ready;
  logic [BLOCK_W-1:0] i2c_data;
  logic               i2c_valid;
  logic               i2c_ready;
  modport master (output sram_data, sram_valid, i2c_data, i2c_valid, input sram_ready, i2c_ready);
  modport slave  (input sram_data, sram_valid, i2c_data, i2c_valid, output sram_ready, i2c_ready);
endinterface

// File: rtl/block_fifo.sv
// block_fifo: synchronous FIFO of tagged cipher blocks with registered occupancy.
module block_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             wr, rd;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q] <= wdata;
  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(wr);
      rd_q  <= rd_q + AW'(rd);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/output_block_buffer.sv
// output_block_buffer: queues finished cipher blocks and drains them in order,
// as an MSB-first byte stream (rw=0) or as whole blocks (rw=1).
module output_block_buffer
  import output_buf_pkg::*;
#(
  parameter int BLOCK_W = 64,
  parameter int BYTE_W  = 8,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   load_enable,
  input  logic                   rw,
  input  logic [BLOCK_W-1:0]     des_out,
  output logic                   full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output_block_buffer_if.master  dst
);
  localparam int NBYTES = BLOCK_W / BYTE_W;
  localparam int IW     = $clog2(NBYTES);
  state_t             state_q;
  logic [BLOCK_W-1:0] sh_q, blk_q;
  logic [IW-1:0]      idx_q;
  logic               overflow_q;
  logic [BLOCK_W:0]   head;
  logic               empty, done, pop;
  block_fifo #(.WIDTH(BLOCK_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk, .n_rst, .push(load_enable), .pop, .wdata({rw, des_out}),
    .rdata(head), .count, .full, .empty
  );
  assign done = (state_q == SER && dst.sram_ready && idx_q == IW'(NBYTES - 1)) ||
                (state_q == PAR && dst.i2c_ready);
  assign pop  = (state_q == IDLE || done) && !empty;
  assign busy           = state_q != IDLE;
  assign dst.sram_valid = state_q == SER;
  assign dst.i2c_valid  = state_q == PAR;
  assign dst.sram_data  = sh_q[BLOCK_W-1 -: BYTE_W];
  assign dst.i2c_data   = blk_q;
  assign overflow       = overflow_q;
  // Each side keeps its own holding register so the idle side's data never moves.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      blk_q      <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= load_enable && full;
      if (pop) begin
        state_q <= head[BLOCK_W] == MODE_I2C ? PAR : SER;
        idx_q   <= '0;
        if (head[BLOCK_W] == MODE_SRAM) sh_q <= head[BLOCK_W-1:0];
        else blk_q <= head[BLOCK_W-1:0];
      end else if (done) begin
        state_q <= IDLE;
        idx_q   <= '0;
      end else if (state_q == SER && dst.sram_ready) begin
        sh_q  <= sh_q << BYTE_W;
        idx_q <= idx_q + IW'(1);
      end
    end
endmodule

// File: tb/tb_output_block_buffer.sv
// tb_output_block_buffer: directed plus random stimulus checked every cycle against
// a queue-based model of occupancy, in-flight block and delivered data.
module tb_output_block_buffer;
  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        load_enable = 1'b0;
  logic        rw = 1'b0;
  logic [63:0] des_out = '0;
  logic        full, overflow, busy;
  logic [2:0]  count;
  output_block_buffer_if #(.BLOCK_W(64), .BYTE_W(8)) bus ();
  output_block_buffer #(.BLOCK_W(64), .BYTE_W(8), .DEPTH(4)) dut (
    .clk, .n_rst, .load_enable, .rw, .des_out, .full, .overflow, .count, .busy, .dst(bus)
  );
  always #5 clk = ~clk;

  logic [64:0] fq[$];
  logic [64:0] cur = '0;
  bit          act = 0;
  int          rem = 0;
  logic [7:0]  last_b = '0;
  logic [63:0] last_blk = '0;
  bit          exp_ovf = 0;
  int          n_chk = 0, n_err = 0;
  bit          pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic verify();
    logic [63:0] sh;
    if (act && !cur[64]) begin
      sh = cur[63:0] << (8 * (8 - rem));
      last_b = sh[63:56];
    end
    if (act && cur[64]) last_blk = cur[63:0];
    chk("count", count, fq.size());
    chk("full", full, fq.size() == 4);
    chk("overflow", overflow, exp_ovf);
    chk("busy", busy, act);
    chk("sram_valid", bus.sram_valid, act && !cur[64]);
    chk("sram_data", bus.sram_data, last_b);
    chk("i2c_valid", bus.i2c_valid, act && cur[64]);
    chk("i2c_data", bus.i2c_data, last_blk);
  endtask

  task automatic step(input bit le, input bit r, input logic [63:0] d, input bit sr, input bit ir);
    bit was_full, done;
    load_enable = le;
    rw = r;
    des_out = d;
    bus.sram_ready = sr;
    bus.i2c_ready = ir;
    @(posedge clk);
    was_full = fq.size() == 4;
    exp_ovf = le && was_full;
    done = act && (cur[64] ? ir : (sr && rem == 1));
    if (act && !cur[64] && sr && !done) rem--;
    if ((!act || done) && fq.size() > 0) begin
      cur = fq.pop_front();
      act = 1;
      rem = 8;
    end else if (done) act = 0;
    if (le && !was_full) fq.push_back({r, d});
    #1 verify();
  endtask

  task automatic do_reset();
    load_enable = 1'b0;
    n_rst = 1'b0;
    #1;
    fq.delete();
    act = 0;
    rem = 0;
    last_b = '0;
    last_blk = '0;
    exp_ovf = 0;
    verify();
    @(posedge clk);
    #1 verify();
    n_rst = 1'b1;
  endtask

  initial begin
    bus.sram_ready = 1'b0;
    bus.i2c_ready = 1'b0;
    #2 do_reset();
    // byte stream with ready held high
    step(1, 0, 64'h1234567890abcdef, 1, 0);
    repeat (10) step(0, 0, '0, 1, 0);
    chk("t1_busy_done", busy, 0);
    // whole block held under backpressure
    step(1, 1, 64'h1234567890abcdef, 0, 0);
    repeat (5) step(0, 0, '0, 0, 0);
    chk("t2_i2c_held", bus.i2c_data, 64'h1234567890abcdef);
    step(0, 0, '0, 0, 1);
    repeat (2) step(0, 0, '0, 0, 0);
    // toggling sram_ready
    step(1, 0, 64'hfedcba9876543210, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 0, '0, pat[i % 6], 0);
    // overfill with consumer stalled
    for (int i = 0; i < 6; i++) step(1, 0, 64'h1111_0000_0000_0000 + 64'(i), 0, 0);
    chk("t4_full", full, 1);
    chk("t4_count", count, 4);
    chk("t4_ovf_pulse", overflow, 1);
    step(0, 0, '0, 0, 0);
    chk("t4_ovf_drop", overflow, 0);
    repeat (50) step(0, 0, '0, 1, 1);
    // SER followed directly by PAR
    step(1, 0, 64'haaaa_bbbb_cccc_dddd, 1, 1);
    step(1, 1, 64'h0123_4567_89ab_cdef, 1, 1);
    repeat (12) step(0, 0, '0, 1, 1);
    // reset in the middle of a byte stream
    step(1, 0, 64'h0102030405060708, 1, 0);
    repeat (4) step(0, 0, '0, 1, 0);
    do_reset();
    chk("t6_count_rst", count, 0);
    step(1, 0, 64'h8877665544332211, 1, 0);
    repeat (10) step(0, 0, '0, 1, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, {$urandom, $urandom},
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/output_block_buffer.md
Name: output_block_buffer

Overview:
- Parametrised successor to the single-register output stage of the Triple-DES core.
- Buffers up to DEPTH finished cipher blocks, each tagged with its rw mode.
- Drains blocks in order: rw=0 blocks go to the SRAM side as a byte stream (MSB byte first, valid/ready); rw=1 blocks go to the I2C side whole (valid/ready).
- Sits between the DES datapath output and the SRAM/I2C interface blocks, and removes data loss when the consumer stalls.

Parameters:
- BLOCK_W, 64, cipher block width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, SRAM transfer width; NBYTES = BLOCK_W/BYTE_W must be at least 2.
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- load_enable  in  1  push des_out and rw this cycle.
- rw  in  1  mode tag: 0 = SRAM byte stream, 1 = I2C block.
- des_out  in  BLOCK_W  cipher block from the DES core.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  one-cycle pulse: a push was rejected.
- count  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the in-flight block.
- busy  out  1  FSM not IDLE.
- sram_data  out  BYTE_W  current byte.
- sram_valid  out  1  sram_data is valid.
- sram_ready  in  1  SRAM side accepts the byte.
- i2c_data  out  BLOCK_W  current block.
- i2c_valid  out  1  i2c_data is valid.
- i2c_ready  in  1  I2C side accepts the block.

Behaviour:
- Reset (async, n_rst=0): all outputs 0, FIFO emptied, FSM to IDLE, byte index 0, shift register 0. A reset mid-transfer discards the in-flight block and all queued blocks.
- Push: on posedge with load_enable=1 and full=0, write {rw, des_out} at the write pointer. count increments the following cycle.
- Push while full: the entry is dropped and overflow pulses high for exactly one cycle. This applies even if a pop happens in the same cycle, because full is evaluated on the registered count.
- Simultaneous push and pop when not full: count is unchanged; pointers wrap modulo DEPTH.
- FSM states: IDLE, SER, PAR.
- IDLE: if count>0, pop the head on the next posedge into the shift register. Go to SER if tag=0 (byte index=0), or PAR if tag=1.
- Latency: a push sampled at edge k into an empty buffer gives valid high after edge k+1.
- SER:
  - sram_valid=1; sram_data = top BYTE_W bits of the shift register.
  - On posedge with sram_ready=1: shift left by BYTE_W and increment the index.
  - On acceptance of byte NBYTES-1: if count>0, pop the next entry in the same edge (no bubble) and enter SER or PAR by its tag. Otherwise go to IDLE and drop sram_valid.
- PAR:
  - i2c_valid=1; i2c_data = the held block.
  - On posedge with i2c_ready=1: same pop-or-IDLE rule as SER.
- Stability: data must not change while valid=1 and ready=0. A ready asserted while valid=0 is ignored. The inactive side's valid stays 0 and its data holds its last value.
- Outputs are registered; there is no combinational path from sram_ready or i2c_ready to any output.
- busy=1 in SER and PAR.

Decomposition:
- Package output_buf_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, SER, PAR};
  - localparams MODE_SRAM=1'b0 and MODE_I2C=1'b1.
- Sub-module block_fifo: synchronous FIFO with parameters WIDTH (=BLOCK_W+1) and DEPTH, ports push/pop/wdata/rdata/count/full/empty, async active-low reset.
- The top level holds the FSM, shift register, byte index and output registers.

Test Plan:
- Reset, then push 64'h1234567890abcdef with rw=0 and sram_ready=1. Required: sram_valid rises one cycle after the push edge; sram_data is 12,34,56,78,90,ab,cd,ef on 8 consecutive cycles; then valid=0 and busy=0.
- Push the same block with rw=1 and hold i2c_ready=0 for 5 cycles. Required: i2c_valid=1 and i2c_data=1234567890abcdef stable throughout; valid drops the cycle after i2c_ready=1; sram_valid stays 0.
- rw=0 block with sram_ready toggling 1,0,0,1,0,1… Required: exactly 8 bytes delivered in order, with no duplicate and no skip.
- sram_ready=0, push 6 blocks back-to-back (DEPTH=4). Required: 1 in flight plus 4 queued, full=1, count=4; the 6th push pulses overflow for one cycle and is never output.
- Push rw=0 block A then rw=1 block B with both readys=1. Required: i2c_valid=1 carrying B on the cycle immediately after A's last byte is accepted, with no idle cycle.
- Assert n_rst=0 after 3 bytes of a SER transfer. Required: all outputs 0 and count=0 immediately. After release, a new push streams from its first byte.
